// File: rtl/maze_game_ctrl_if.sv
// Signal bundle between the maze game sequencer and its environment.
// The debouncers and the datapath sit on the slave side.
interface maze_game_ctrl_if;
    logic       start_btn;
    logic       map_btn;
    logic       suc;
    logic [6:0] step_cnt;
    logic       game_start;
    logic       map_sel;
    logic [4:0] time_sign;
    logic [1:0] state;
    logic [6:0] best_step;
    logic       tick;

    modport master (
        input  start_btn, map_btn, suc, step_cnt,
        output game_start, map_sel, time_sign, state, best_step, tick
    );

    modport slave (
        output start_btn, map_btn, suc, step_cnt,
        input  game_start, map_sel, time_sign, state, best_step, tick
    );
endinterface

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: idle/play/win/lose flow, one-second countdown,
// map selection and per-map best-step records.
module maze_game_ctrl #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned TIME_LIMIT = 30
) (
    input logic             clk,
    input logic             rst,
    maze_game_ctrl_if.master bus
);

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);
    localparam logic [4:0]   TimeInit = 5'(TIME_LIMIT);
    localparam logic [6:0]   NoRecord = 7'h7F;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StPlay = 2'b01;
    localparam logic [1:0] StWin  = 2'b10;
    localparam logic [1:0] StLose = 2'b11;

    logic [1:0]      state_q, state_d;
    logic            map_q, map_d;
    logic [4:0]      time_q, time_d;
    logic [PW-1:0]   pres_q, pres_d;
    logic            gs_q, gs_d;
    logic            tick_q, tick_d;
    logic [1:0][6:0] best_q, best_d;
    logic            last_tick;

    assign last_tick = (pres_q == PresMax);

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        time_d  = time_q;
        pres_d  = pres_q;
        gs_d    = 1'b0;
        tick_d  = 1'b0;
        best_d  = best_q;
        unique case (state_q)
            StIdle: begin
                pres_d = '0;
                if (bus.start_btn) begin
                    state_d = StPlay;
                    gs_d    = 1'b1;
                    time_d  = TimeInit;
                end else if (bus.map_btn) begin
                    map_d = ~map_q;
                end
            end
            StPlay: begin
                if (bus.start_btn) begin
                    gs_d   = 1'b1;
                    time_d = TimeInit;
                    pres_d = '0;
                end else if (bus.suc) begin
                    // A win beats a coinciding final tick: no decrement, no tick pulse.
                    state_d = StWin;
                    if (bus.step_cnt < best_q[map_q]) begin
                        best_d[map_q] = bus.step_cnt;
                    end
                end else begin
                    pres_d = last_tick ? '0 : pres_q + 1'b1;
                    if (last_tick) begin
                        tick_d = 1'b1;
                        if (time_q <= 5'd1) begin
                            time_d  = 5'd0;
                            state_d = StLose;
                        end else begin
                            time_d = time_q - 5'd1;
                        end
                    end
                end
            end
            StWin, StLose: begin
                if (bus.start_btn) begin
                    state_d = StIdle;
                    time_d  = TimeInit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            map_q   <= 1'b0;
            time_q  <= TimeInit;
            pres_q  <= '0;
            gs_q    <= 1'b0;
            tick_q  <= 1'b0;
            best_q  <= {NoRecord, NoRecord};
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            time_q  <= time_d;
            pres_q  <= pres_d;
            gs_q    <= gs_d;
            tick_q  <= tick_d;
            best_q  <= best_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.map_sel    = map_q;
    assign bus.time_sign  = time_q;
    assign bus.game_start = gs_q;
    assign bus.tick       = tick_q;
    assign bus.best_step  = best_q[map_q];

endmodule

// File: doc/maze_game_ctrl.md
# maze_game_ctrl

Game sequencer for the 8x8 LED-matrix maze datapath. It turns debounced start and map-change pulses into a four-state game flow: idle, play, win, lose. It generates the one-second countdown consumed by the datapath as `time_sign`, selects which of the two maps is active, and keeps a best-step record for each map. It sits between the button debouncers and the maze datapath, and also drives the time display path.

## Interface
Parameters:
- TICK_DIV, 1000: clk cycles per countdown tick. Legal range 2..2^20.
- TIME_LIMIT, 30: seconds loaded at game start. Legal range 1..31.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start_btn  in  1  one-cycle pulse from the start-key debouncer
- map_btn  in  1  one-cycle pulse from the map-key debouncer
- suc  in  1  datapath "player on terminal" level
- step_cnt  in  7  datapath step counter
- game_start  out  1  one-cycle pulse telling the datapath to load the start point and clear step_cnt
- map_sel  out  1  active map: 0 = map 1, 1 = map 2
- time_sign  out  5  remaining seconds; 0 means time is up
- state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
- best_step  out  7  best step count for the current map_sel; 7'h7F means no record
- tick  out  1  one-cycle pulse on each countdown decrement, for the display refresh

## Operation
Reset values (asynchronous):
- state = IDLE, map_sel = 0, time_sign = TIME_LIMIT
- game_start = 0, tick = 0, prescaler = 0
- both best records = 7'h7F

IDLE:
- map_btn toggles map_sel.
- start_btn: pulse game_start, load time_sign = TIME_LIMIT, clear the prescaler, go to PLAY.
- The prescaler is held at 0.

PLAY:
- The prescaler counts 0..TICK_DIV-1 and wraps. At TICK_DIV-1, tick pulses and time_sign decrements.
- suc = 1: go to WIN and freeze time_sign.
- A tick while time_sign == 1: time_sign becomes 0, go to LOSE.
- suc = 1 in the same cycle as the final tick: WIN wins; time_sign stays at 1 (no decrement).
- start_btn: restart. Pulse game_start, reload TIME_LIMIT, clear the prescaler, stay in PLAY. start_btn has priority over suc and tick in that cycle.
- map_btn is ignored, so the map cannot change mid-game.

Entering WIN (same edge as the transition):
- If step_cnt < best[map_sel], then best[map_sel] = step_cnt.
- This is an unsigned 7-bit compare. step_cnt = 7'h7F never replaces an existing record.

WIN / LOSE:
- time_sign is frozen and the prescaler is held.
- start_btn goes to IDLE and reloads time_sign = TIME_LIMIT.
- map_btn is ignored.

General rules:
- best_step = best[map_sel] combinationally; it follows map_sel toggles in IDLE.
- time_sign never underflows below 0 and never exceeds TIME_LIMIT.
- start_btn and map_btn arriving in the same cycle in IDLE: start wins, map_sel is unchanged.

## Timing
- All state, counter and output updates occur on the rising edge of clk. Reset clears everything immediately and asynchronously.
- game_start is high for exactly the one cycle after the start_btn cycle. The state register reads PLAY in that same cycle.
- Tick spacing in PLAY is exactly TICK_DIV cycles. The first tick comes TICK_DIV cycles after game_start.
- From suc rising to state = WIN: 1 cycle. The best record is updated in the same cycle.
- The last tick to state = LOSE and time_sign = 0: same edge.
- Reset during PLAY: next cycle is IDLE with time_sign = TIME_LIMIT. Best records are lost (cleared to 7'h7F).
- Button pulses longer than one cycle are not expected; each high cycle counts as a press.

## Test plan
Bench uses TICK_DIV = 4 and TIME_LIMIT = 3.

1. Reset, then check outputs:
   - Expect state = 00, time_sign = 3, map_sel = 0, best_step = 7'h7F, game_start = 0.
2. Timeout path:
   - Stimulus: start_btn, then wait with no suc.
   - Expect game_start high for 1 cycle and state = 01.
   - Expect ticks at +4, +8 and +12 cycles; time_sign steps 2 → 1 → 0.
   - Expect state = 11 on the third tick, with time_sign frozen at 0.
3. Win and record per map:
   - Stimulus: in PLAY, drive step_cnt = 12 and raise suc.
   - Expect state = 10 next cycle and best_step = 12.
   - Stimulus: start_btn to IDLE, map_btn to toggle map.
   - Expect map_sel = 1 and best_step = 7'h7F; toggling back shows 12.
4. Record only improves:
   - Stimulus: win again on map 0 with step_cnt = 15, then with step_cnt = 9.
   - Expect best_step to stay 12 after the first, then become 9.
5. Simultaneous events and ignored input:
   - Stimulus: suc on the same cycle as the final tick.
   - Expect state = WIN and time_sign = 1.
   - Stimulus: start_btn together with suc in PLAY.
   - Expect a restart: time_sign = 3 and state = PLAY.
   - Stimulus: map_btn during PLAY.
   - Expect map_sel unchanged.
6. Reset mid-game:
   - Stimulus: drop rst while time_sign = 2 in PLAY.
   - Expect outputs at reset values immediately, before the next clock edge.
